mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-outstanding data-memory port between NUM_REQ requesters.
- Requester 0 is instruction fetch; requester 1 is load/store; higher indices are optional, e.g. a loader or debug master.
- Sits between core_model's fetch/LSU stages and the memory model.
- Sequences each transfer as accept → issue → wait-for-response, and routes the response back to the owning requester.
- A watchdog flags memory responses that never arrive.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 64, cycles in WAIT_RESP before err_timeout_o sets; 0 disables the watchdog.
- XLEN, riscv_pkg::XLEN, address and data width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_addr_i  in  NUM_REQ×XLEN  byte address.
- req_we_i  in  NUM_REQ  1 = write.
- req_wdata_i  in  NUM_REQ×XLEN  write data.
- req_wstrb_i  in  NUM_REQ×XLEN/8  byte strobes.
- resp_valid_o  out  NUM_REQ  one-cycle response pulse to the owner.
- resp_rdata_o  out  XLEN  read data, shared bus, qualified by resp_valid_o.
- mem_req_valid_o  out  1  request to memory.
- mem_req_ready_i  in  1  memory accepts.
- mem_addr_o  out  XLEN  latched address.
- mem_we_o  out  1  latched write enable.
- mem_wdata_o  out  XLEN  latched write data.
- mem_wstrb_o  out  XLEN/8  latched strobes.
- mem_resp_valid_i  in  1  memory response; issued for both reads and writes.
- mem_resp_rdata_i  in  XLEN  memory read data.
- busy_o  out  1  state != IDLE.
- owner_o  out  $clog2(NUM_REQ)  current owner index.
- err_timeout_o  out  1  sticky watchdog error.

Behaviour:
- Reset (rstn=0, asynchronous):
  - State = IDLE; all valid/ready outputs = 0.
  - Latched mem_* payload = 0; owner_o = 0; rr pointer = 0.
  - Watchdog counter = 0; err_timeout_o = 0.
  - Reset mid-transfer drops the transfer silently; no resp_valid_o pulse is produced.
- IDLE:
  - Grant is combinational from req_valid_i.
  - req_ready_o[g] = 1 for the granted index only; payload is latched at the clock edge; owner_o <= g; next state ISSUE.
  - No valid request: remain IDLE, req_ready_o = 0.
- ISSUE:
  - mem_req_valid_o = 1 with the latched payload held stable.
  - mem_req_ready_i = 1 → WAIT_RESP.
  - Otherwise hold; valid must not drop while ready is low.
- WAIT_RESP:
  - Watchdog counts while in this state.
  - mem_resp_valid_i = 1 → resp_valid_o[owner] = 1 the same cycle (combinational pass-through); resp_rdata_o = mem_resp_rdata_i; next state IDLE.
  - Counter reaching TIMEOUT_CYCLES sets err_timeout_o, which is sticky until reset. State stays WAIT_RESP.
- Minimum transaction latency: accept (cycle 0), issue (cycle 1), response no earlier than cycle 2. No new acceptance occurs in the response cycle; the next grant is earliest in the following cycle.
- Grant policy (default, macro off): fixed priority, lowest index wins, so fetch beats LSU.
- Boundary cases:
  - mem_resp_valid_i outside WAIT_RESP is ignored.
  - mem_req_ready_i outside ISSUE is ignored.
  - req_valid_i deasserted while not granted: no effect.
- resp_rdata_o is undefined when no resp_valid_o bit is set; it is driven with mem_resp_rdata_i.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin grant. The search starts at rr_ptr; on every grant rr_ptr <= g+1, wrapping at NUM_REQ. rr_ptr resets to 0.
- Undefined: fixed priority, lowest index wins. rr_ptr logic is absent.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_e {IDLE, ISSUE, WAIT_RESP};
  - mem_req_t packed struct {addr, we, wdata, wstrb};
  - NUM_REQ_MAX = 4.
  - Uses riscv_pkg::XLEN.
- One sub-module, mem_arb_grant: combinational one-hot grant from valid vector and rr_ptr, with the priority/round-robin choice selected by the macro.
- The FSM, payload latch and watchdog stay in mem_port_arbiter.

Test Plan:
- Single read: req 1 valid with addr 0x0000_1000; memory ready immediately; response 2 cycles later with rdata 0xDEAD_BEEF → req_ready_o = 2'b10 at cycle 0; mem_req_valid_o at cycle 1; resp_valid_o = 2'b10 with rdata 0xDEAD_BEEF at cycle 3.
- Contention, macro off: both valid continuously, each memory response 1 cycle after issue → grants are 0,0,0…; requester 1 starves.
- Contention, macro on: same stimulus → grants alternate 0,1,0,1; rr_ptr wraps to 0 after index 1.
- Backpressure: mem_req_ready_i held 0 for 5 cycles with a write of addr 0x10, data 0x1234_5678, strobe 4'b0011 → mem_* outputs stable all 5 cycles; one acceptance only; write response routed to the owner.
- Watchdog: TIMEOUT_CYCLES = 8, no response → err_timeout_o = 1 after 8 cycles in WAIT_RESP and stays 1; a late response still produces one resp_valid_o pulse and the arbiter returns to IDLE.
- Reset mid-transfer: rstn = 0 while in WAIT_RESP → all outputs 0 immediately; no resp_valid_o pulse; after rstn = 1 a fresh request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int NUM_REQ_MAX = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  // Payload captured at acceptance and held toward memory until the handshake.
  typedef struct packed {
    logic [riscv_pkg::XLEN-1:0]   addr;
    logic                         we;
    logic [riscv_pkg::XLEN-1:0]   wdata;
    logic [riscv_pkg::XLEN/8-1:0] wstrb;
  } mem_req_t;

  // Encode a one-hot (or zero) vector into the index of its set bit.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ_MAX-1:0] onehot);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ_MAX; i++) begin
      idx = idx | (onehot[i] ? 2'(i) : 2'd0);
    end
    return idx;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/riscv_pkg.sv
// Core-wide architectural constants shared by the core_model slice.
package riscv_pkg;

  localparam int XLEN = 32;

endpackage : riscv_pkg

// File: rtl/mem_arb_grant.sv
// One-hot grant selection for mem_port_arbiter.
// MEM_ARB_ROUND_ROBIN_EN defined: round-robin search starting at rr_ptr_i.
// MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins.
module mem_arb_grant #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
`endif
  output logic [NUM_REQ-1:0]         grant_o
);

  // Lowest set bit of v, as a one-hot vector.
  function automatic logic [NUM_REQ-1:0] first_set(input logic [NUM_REQ-1:0] v);
    logic [NUM_REQ-1:0] g;
    logic               seen;
    g    = '0;
    seen = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      g[i] = v[i] & ~seen;
      seen = seen | v[i];
    end
    return g;
  endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [NUM_REQ-1:0] w_rot_valid;
  logic [NUM_REQ-1:0] w_rot_grant;

  // Rotate so rr_ptr_i sits at bit 0, pick the first, rotate the pick back.
  always_comb begin
    w_rot_valid = NUM_REQ'({valid_i, valid_i} >> rr_ptr_i);
    w_rot_grant = first_set(w_rot_valid);
    grant_o     = NUM_REQ'(({w_rot_grant, w_rot_grant} << rr_ptr_i) >> NUM_REQ);
  end
`else
  // Fixed priority: requester 0 (fetch) always wins over higher indices.
  always_comb begin
    grant_o = first_set(valid_i);
  end
`endif

endmodule : mem_arb_grant

// File: rtl/mem_port_arbiter.sv
// Single-outstanding data-memory port shared by NUM_REQ requesters
// (0 = fetch, 1 = load/store, higher = loader/debug). Each transfer runs
// accept -> issue -> wait-for-response; the response is routed to its owner.
// A sticky watchdog flags responses that never arrive.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of
// fixed-priority grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int XLEN           = riscv_pkg::XLEN
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ-1:0][XLEN-1:0]      req_addr_i,
  input  logic [NUM_REQ-1:0]                req_we_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]      req_wdata_i,
  input  logic [NUM_REQ-1:0][XLEN/8-1:0]    req_wstrb_i,
  output logic [NUM_REQ-1:0]                resp_valid_o,
  output logic [XLEN-1:0]                   resp_rdata_o,
  output logic                              mem_req_valid_o,
  input  logic                              mem_req_ready_i,
  output logic [XLEN-1:0]                   mem_addr_o,
  output logic                              mem_we_o,
  output logic [XLEN-1:0]                   mem_wdata_o,
  output logic [XLEN/8-1:0]                 mem_wstrb_o,
  input  logic                              mem_resp_valid_i,
  input  logic [XLEN-1:0]                   mem_resp_rdata_i,
  output logic                              busy_o,
  output logic [$clog2(NUM_REQ)-1:0]        owner_o,
  output logic                              err_timeout_o
);

  localparam int OWN_W = $clog2(NUM_REQ);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  mem_req_t           r_req;
  mem_req_t           w_sel;
  logic [OWN_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] w_grant;
  logic [OWN_W-1:0]   w_grant_idx;
  logic               w_accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [OWN_W-1:0]   r_rr_ptr;
`endif

  mem_arb_grant #(
    .NUM_REQ (NUM_REQ)
  ) u_grant (
    .valid_i  (req_valid_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .rr_ptr_i (r_rr_ptr),
`endif
    .grant_o  (w_grant)
  );

  assign w_grant_idx = OWN_W'(onehot_to_idx(NUM_REQ_MAX'(w_grant)));

  // Select the granted requester's payload (grant is one-hot, so OR-merge).
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel.addr  = w_sel.addr  | (req_addr_i[i]  & {XLEN{w_grant[i]}});
      w_sel.we    = w_sel.we    | (req_we_i[i]    & w_grant[i]);
      w_sel.wdata = w_sel.wdata | (req_wdata_i[i] & {XLEN{w_grant[i]}});
      w_sel.wstrb = w_sel.wstrb | (req_wstrb_i[i] & {(XLEN/8){w_grant[i]}});
    end
  end

  // Next-state and handshake outputs; response passes straight through.
  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    req_ready_o     = '0;
    mem_req_valid_o = 1'b0;
    resp_valid_o    = '0;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          req_ready_o = w_grant;
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          w_state_nxt = WAIT_RESP;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      WAIT_RESP: begin
        if (mem_resp_valid_i) begin
          resp_valid_o = NUM_REQ'(1) << r_owner;
          w_state_nxt  = IDLE;
        end else begin
          w_state_nxt  = WAIT_RESP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, owner and payload registers; payload captured only on acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner <= w_grant_idx;
        r_req   <= w_sel;
      end
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Round-robin pointer moves just past the requester that won.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_grant_idx == OWN_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + OWN_W'(1);
    end
  end
`endif

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
      logic [WD_W-1:0] r_wd_cnt;
      logic            r_err;

      // Count cycles waiting for a response; error is sticky until reset.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_wd_cnt <= '0;
          r_err    <= 1'b0;
        end else if ((r_state == WAIT_RESP) && !mem_resp_valid_i) begin
          if (r_wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
          if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            r_err <= 1'b1;
          end
        end else begin
          r_wd_cnt <= '0;
        end
      end

      assign err_timeout_o = r_err;
    end else begin : g_no_wdog
      assign err_timeout_o = 1'b0;
    end
  endgenerate

  assign resp_rdata_o = mem_resp_rdata_i;
  assign mem_addr_o   = r_req.addr;
  assign mem_we_o     = r_req.we;
  assign mem_wdata_o  = r_req.wdata;
  assign mem_wstrb_o  = r_req.wstrb;
  assign busy_o       = (r_state != IDLE);
  assign owner_o      = r_owner;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
// A behavioural memory feeds responses; expected responses go into a
// scoreboard queue at acceptance and are popped when resp_valid_o pulses.
module tb_mem_port_arbiter;

  localparam int NR = 2;
  localparam int XL = 32;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NR-1:0]        req_valid_i, req_ready_o, req_we_i, resp_valid_o;
  logic [NR-1:0][XL-1:0] req_addr_i, req_wdata_i;
  logic [NR-1:0][3:0]   req_wstrb_i;
  logic [XL-1:0]        resp_rdata_o, mem_addr_o, mem_wdata_o, mem_resp_rdata_i;
  logic                 mem_req_valid_o, mem_req_ready_i, mem_we_o, mem_resp_valid_i;
  logic                 busy_o, err_timeout_o;
  logic [3:0]           mem_wstrb_o;
  logic [0:0]           owner_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .XLEN(XL)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_rdata_i(mem_resp_rdata_i), .busy_o(busy_o), .owner_o(owner_o),
    .err_timeout_o(err_timeout_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          owner;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  int   n_resp = 0;

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [int unsigned];
  int          bp_left  = 0;
  int          resp_gap = 1;
  bit          mem_hold = 1'b0;
  bit          stray    = 1'b0;
  bit          mm_pend  = 1'b0;
  int          mm_cnt   = 0;
  int          n_mem_acc = 0;
  logic [31:0] mm_rdata, mm_tmp, cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: ready/response driven 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_rdata_i = 32'h0;
    if (!rstn) begin
      mm_pend = 1'b0;
    end else begin
      if (mm_pend) begin
        mm_cnt--;
        if (mm_cnt <= 0 && !mem_hold) begin
          mem_resp_valid_i = 1'b1;
          mem_resp_rdata_i = mm_rdata;
          mm_pend          = 1'b0;
        end
      end
      if (mem_req_valid_o) begin
        if (bp_left > 0) begin
          bp_left--;
        end else begin
          mem_req_ready_i = 1'b1;
          n_mem_acc++;
          cap_addr  = mem_addr_o;
          cap_wdata = mem_wdata_o;
          cap_wstrb = mem_wstrb_o;
          if (mem_we_o) begin
            mm_tmp = mem_rd(mem_addr_o);
            for (int b = 0; b < 4; b++)
              if (mem_wstrb_o[b]) mm_tmp[8*b +: 8] = mem_wdata_o[8*b +: 8];
            mem_arr[mem_addr_o] = mm_tmp;
            mm_rdata = 32'h0;
          end else begin
            mm_rdata = mem_rd(mem_addr_o);
          end
          mm_pend = 1'b1;
          mm_cnt  = resp_gap;
        end
      end else if (stray) begin
        mem_req_ready_i = 1'b1;
        if (!busy_o) begin
          mem_resp_valid_i = 1'b1;
          mem_resp_rdata_i = 32'hBAD0_BAD0;
        end
      end
    end
  end

  // Response monitor: every pulse must match the oldest expectation.
  always @(posedge clk) begin : mon
    exp_t        e;
    logic [1:0]  one;
    #2;
    if (resp_valid_o != 2'b00) begin
      n_resp++;
      if (sb.size() == 0) begin
        chk("resp_unexpected", resp_valid_o, 2'b00);
      end else begin
        e   = sb.pop_front();
        one = 2'b01 << e.owner;
        chk("resp_owner", resp_valid_o, one);
        chk("resp_rdata", resp_rdata_o, e.rdata);
      end
    end
  end

  // ---------------- grant reference ----------------
  int rr_model = 0;

  function automatic logic [1:0] exp_grant(input logic [1:0] v);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 2; k++) begin
      int i;
      i = (rr_model + k) % 2;
      if (v[i]) return 2'b01 << i;
    end
    return 2'b00;
`else
    if (v[0]) return 2'b01;
    if (v[1]) return 2'b10;
    return 2'b00;
`endif
  endfunction

  // ---------------- timing helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cyc();
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic single_xfer(input int r, input logic [31:0] a, input logic we,
                             input logic [31:0] wd, input logic [3:0] st,
                             input logic [31:0] exp_rd, input string tag);
    cyc();
    req_valid_i    = 2'b01 << r;
    req_addr_i[r]  = a;
    req_we_i[r]    = we;
    req_wdata_i[r] = wd;
    req_wstrb_i[r] = st;
    #1;
    chk({tag, "_ready"}, req_ready_o, 2'b01 << r);
    sb.push_back('{owner: r, rdata: exp_rd});
    rr_model = (r + 1) % 2;
    cyc();
    req_valid_i = 2'b00;
    #1;
    chk({tag, "_issue"}, mem_req_valid_o, 1'b1);
    wait_idle(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int         gap, gi, n_g1, acc0;
    logic [1:0] eg;

    rstn        = 1'b0;
    req_valid_i = '0;
    req_addr_i  = '0;
    req_we_i    = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    mem_arr[32'h1000] = 32'hDEAD_BEEF;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", req_ready_o, 2'b00);
    chk("rst_mreq", mem_req_valid_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", {mem_we_o, mem_wstrb_o, mem_wdata_o}, 37'h0);
    chk("rst_owner", owner_o, 1'b0);
    chk("rst_err", err_timeout_o, 1'b0);
    chk("rst_resp", resp_valid_o, 2'b00);
    cyc();
    rstn = 1'b1;
    #1;

    // ---- single read, exact cycle timing ----
    resp_gap = 2;
    cyc();
    req_valid_i   = 2'b10;
    req_addr_i[1] = 32'h0000_1000;
    req_we_i[1]   = 1'b0;
    #1;
    chk("t1_ready", req_ready_o, 2'b10);
    sb.push_back('{owner: 1, rdata: 32'hDEAD_BEEF});
    rr_model = 0;
    cyc();
    req_valid_i = 2'b00;
    #1;
    chk("t1_issue", mem_req_valid_o, 1'b1);
    chk("t1_addr", mem_addr_o, 32'h0000_1000);
    chk("t1_we", mem_we_o, 1'b0);
    chk("t1_owner", owner_o, 1'b1);
    step();
    chk("t1_wait_mreq", mem_req_valid_o, 1'b0);
    chk("t1_wait_busy", busy_o, 1'b1);
    chk("t1_wait_resp", resp_valid_o, 2'b00);
    step();
    chk("t1_resp", resp_valid_o, 2'b10);
    chk("t1_rdata", resp_rdata_o, 32'hDEAD_BEEF);
    step();
    chk("t1_done", busy_o, 1'b0);

    // ---- stray ready/response while idle are ignored ----
    stray = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t2_busy", busy_o, 1'b0);
      chk("t2_resp", resp_valid_o, 2'b00);
    end
    stray = 1'b0;
    step();

    // ---- contention, both requesters always valid ----
    resp_gap = 1;
    n_g1     = 0;
    cyc();
    req_valid_i   = 2'b11;
    req_addr_i[0] = 32'h0000_0100;
    req_addr_i[1] = 32'h0000_0200;
    req_we_i      = 2'b00;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        gap = 1;
        step();
        while (req_ready_o == 2'b00 && gap < 10) begin
          step();
          gap++;
        end
        chk("t3_spacing", gap, 3);
      end
      eg = exp_grant(req_valid_i);
      chk("t3_grant", req_ready_o, eg);
      gi = (eg == 2'b10) ? 1 : 0;
      sb.push_back('{owner: gi, rdata: mem_rd(req_addr_i[gi])});
      rr_model = (gi + 1) % 2;
      if (gi == 1) n_g1++;
    end
    cyc();
    req_valid_i = 2'b00;
    #1;
    wait_idle("t3");
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("t3_req1_grants", n_g1, 3);
`else
    chk("t3_req1_grants", n_g1, 0);
`endif

    // ---- backpressure on a write ----
    bp_left = 5;
    acc0    = n_mem_acc;
    cyc();
    req_valid_i    = 2'b01;
    req_addr_i[0]  = 32'h0000_0010;
    req_we_i[0]    = 1'b1;
    req_wdata_i[0] = 32'h1234_5678;
    req_wstrb_i[0] = 4'b0011;
    #1;
    chk("t4_ready", req_ready_o, 2'b01);
    sb.push_back('{owner: 0, rdata: 32'h0});
    rr_model = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      req_valid_i    = 2'b10;
      req_addr_i[0]  = 32'hFFFF_FFF0;
      req_wdata_i[0] = 32'h0;
      #1;
      chk("t4_hold_valid", mem_req_valid_o, 1'b1);
      chk("t4_hold_addr", mem_addr_o, 32'h0000_0010);
      chk("t4_hold_wr", {mem_we_o, mem_wstrb_o, mem_wdata_o}, {1'b1, 4'b0011, 32'h1234_5678});
      chk("t4_no_accept", req_ready_o, 2'b00);
    end
    cyc();
    req_valid_i = 2'b00;
    req_we_i    = 2'b00;
    #1;
    chk("t4_issue_hs", mem_req_valid_o, 1'b1);
    wait_idle("t4");
    chk("t4_one_issue", n_mem_acc - acc0, 1);
    chk("t4_cap", {cap_wstrb, cap_addr, cap_wdata}, {4'b0011, 32'h10, 32'h1234_5678});
    step();
    chk("t4_no_stale_req", busy_o, 1'b0);
    single_xfer(1, 32'h0000_0010, 1'b0, 32'h0, 4'h0, 32'hA5A5_5678, "t4_rb");

    // ---- watchdog ----
    mem_hold = 1'b1;
    cyc();
    req_valid_i   = 2'b10;
    req_addr_i[1] = 32'h0000_0300;
    #1;
    chk("t5_ready", req_ready_o, 2'b10);
    sb.push_back('{owner: 1, rdata: 32'hA5A5_0300});
    rr_model = 0;
    cyc();
    req_valid_i = 2'b00;
    stray       = 1'b1;
    #1;
    chk("t5_issue", mem_req_valid_o, 1'b1);
    for (int i = 2; i <= 9; i++) begin
      step();
      chk("t5_err_early", err_timeout_o, 1'b0);
      chk("t5_mreq_low", mem_req_valid_o, 1'b0);
    end
    step();
    chk("t5_err_set", err_timeout_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_err_sticky", err_timeout_o, 1'b1);
      chk("t5_still_wait", busy_o, 1'b1);
    end
    stray    = 1'b0;
    mem_hold = 1'b0;
    step();
    chk("t5_late_resp", resp_valid_o, 2'b10);
    step();
    chk("t5_back_idle", busy_o, 1'b0);
    chk("t5_err_kept", err_timeout_o, 1'b1);

    // ---- reset while waiting for a response ----
    mem_hold = 1'b1;
    cyc();
    req_valid_i   = 2'b10;
    req_addr_i[1] = 32'h0000_0400;
    #1;
    chk("t6_ready", req_ready_o, 2'b10);
    sb.push_back('{owner: 1, rdata: 32'hA5A5_0400});
    cyc();
    req_valid_i = 2'b00;
    #1;
    step();
    chk("t6_in_wait", busy_o, 1'b1);
    #1;
    rstn     = 1'b0;
    sb.delete();
    mem_hold = 1'b0;
    #1;
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_owner", owner_o, 1'b0);
    chk("t6_rst_err", err_timeout_o, 1'b0);
    chk("t6_rst_addr", mem_addr_o, 32'h0);
    chk("t6_rst_valids", {resp_valid_o, req_ready_o, mem_req_valid_o}, 5'b0);
    repeat (2) step();
    cyc();
    rstn = 1'b1;
    #1;
    rr_model = 0;
    step();
    single_xfer(1, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, "t6_fresh");

    step();
    chk("sb_drained", sb.size(), 0);
    chk("resp_count", n_resp, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter
